// File: rtl/imm_decode_q_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_q_if
// Description : Enqueue/dequeue handshake bundle for the imm_decode_q queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_decode_q_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
    logic [CW-1:0]   occupancy;

    modport master (
        output in_valid, in_inst, in_pc, in_imm_src, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_pc, out_illegal, occupancy
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_imm_src, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_pc, out_illegal, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/imm_decode_q.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_q
// Description : RV immediate decode (I/U/J/S/B, optional Z via IMM_DECODE_CSR_EN)
//               with pc+imm target, buffered in a DEPTH-entry valid/ready queue.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       flush,
    imm_decode_q_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic [XLEN-1:0]    w_target;
    logic               w_illegal;
    logic               w_enq;
    logic               w_deq;
    logic               w_unused;
    logic [31:0]        w_inst;

    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic [XLEN-1:0]    r_imm    [DEPTH];
    logic [XLEN-1:0]    r_target [DEPTH];
    logic [XLEN-1:0]    r_pc     [DEPTH];
    logic               r_ill    [DEPTH];

    assign w_inst   = bus.in_inst;
    assign w_unused = ^w_inst[6:0];

    // Every format fits a 32-bit signed value; widening to XLEN is one sign-extension.
    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (bus.in_imm_src)
            3'b000: w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            3'b001: w_imm32 = {w_inst[31:12], 12'b0};
            3'b010: w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                               w_inst[30:21], 1'b0};
            3'b011: w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            3'b100: w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                               w_inst[11:8], 1'b0};
`ifdef IMM_DECODE_CSR_EN
            3'b101: w_imm32 = {27'b0, w_inst[19:15]};
`endif
            default: begin
                w_imm32   = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_imm    = XLEN'(w_imm32);
    assign w_target = bus.in_pc + w_imm;

    assign bus.in_ready  = (r_count != CW'(DEPTH)) && !flush;
    assign bus.out_valid = (r_count != '0);
    assign w_enq         = bus.in_valid && bus.in_ready;
    assign w_deq         = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_imm[i]    <= '0;
                r_target[i] <= '0;
                r_pc[i]     <= '0;
                r_ill[i]    <= 1'b0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_imm[r_tail]    <= w_imm;
                r_target[r_tail] <= w_target;
                r_pc[r_tail]     <= bus.in_pc;
                r_ill[r_tail]    <= w_illegal;
                r_tail           <= r_tail + PW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_imm     = r_imm[r_head];
    assign bus.out_target  = r_target[r_head];
    assign bus.out_pc      = r_pc[r_head];
    assign bus.out_illegal = r_ill[r_head];
    assign bus.occupancy   = r_count;
endmodule
`default_nettype wire
